spi_sclk_edge_tracker: RTL
==========================

Name: spi_sclk_edge_tracker

Overview:
- Next-generation SCLK analyser for the SPI slave path.
- Oversamples the raw SCLK wire, synchronises and glitch-filters it, and classifies each edge by SPI mode; CPOL and CPHA are selectable at run time.
- Emits one-cycle sample/shift strobes, a bit index, and frame-done/timeout status to the slave shift register and its control FSM.
- Replaces the fixed-CPOL, fixed-timing analyser with edge-true detection, a programmable frame length and a stall watchdog.

Parameters:
- SYNC_STAGES, 2, flops in the SCLK synchroniser chain (minimum 2).
- FILTER_LEN, 3, consecutive equal synchronised samples required to accept a level change (minimum 1).
- BIT_CNT_MAX, 32, largest supported frame length in bits.
- BIT_CNT_W, 6, width of the bit counter and frame-length port; must hold BIT_CNT_MAX.
- TIMEOUT_CYCLES, 1024, clk cycles without a filtered edge in RUN before a timeout is declared.
- TIMEOUT_W, 11, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- im_work_en  in  1  frame enable; low aborts and returns the block to IDLE.
- im_cpol  in  1  SCLK idle level.
- im_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- im_frame_bits  in  BIT_CNT_W  bits per frame.
- im_sclk_wire  in  1  asynchronous SCLK from the pad.
- om_sample_stb  out  1  one-cycle pulse: capture MOSI now.
- om_shift_stb  out  1  one-cycle pulse: drive the next MISO bit now.
- om_bit_idx  out  BIT_CNT_W  number of samples taken in the current frame.
- om_frame_done  out  1  one-cycle pulse after the final sample.
- om_timeout  out  1  one-cycle pulse on watchdog expiry.
- om_mode_err  out  1  level: SCLK was not at im_cpol when the frame was armed.
- om_busy  out  1  high in ARM and RUN.

Behaviour:
- Reset (rst_n low at a clk edge):
  - all outputs 0; FSM goes to IDLE; counters cleared.
  - synchroniser and filter load 0.
- Synchroniser and filter:
  - SYNC_STAGES flop chain, then a FILTER_LEN-deep history.
  - The filtered level changes only when all FILTER_LEN history entries equal the new level.
- Edge detection and latency:
  - An edge is any change of the filtered level, registered into a one-cycle strobe.
  - Latency is SYNC_STAGES+FILTER_LEN+1 clk cycles from the first clk edge that samples the new SCLK level to the strobe (6 with defaults).
  - Pulses shorter than FILTER_LEN clk cycles after synchronisation produce no strobe.
- Edge classification:
  - Leading edge = filtered level leaves the latched CPOL value.
  - Trailing edge = filtered level returns to the latched CPOL value.
  - CPHA=0: sample on leading, shift on trailing.
  - CPHA=1: shift on leading, sample on trailing.
- Latching:
  - im_cpol, im_cpha and im_frame_bits are latched on the IDLE->ARM transition.
  - Later changes are ignored until the next IDLE.
  - A latched frame length of 0 or above BIT_CNT_MAX is treated as BIT_CNT_MAX.
- FSM states (all states go to IDLE on the cycle after im_work_en samples low; counters clear):
  - IDLE: all strobes 0. Goes to ARM when im_work_en samples 1.
  - ARM, filtered level == latched CPOL: goes to RUN next cycle; om_mode_err=0.
  - ARM, level mismatch: stays in ARM; om_mode_err=1 until the level matches, then goes to RUN. Edges seen in ARM are discarded.
  - RUN: strobes are active.
    - om_bit_idx increments on each om_sample_stb.
    - On the sample that makes om_bit_idx equal the frame length, go to DONE; om_frame_done pulses one cycle later.
  - DONE: all strobes suppressed, including the trailing shift edge of CPHA=0. om_bit_idx holds. Waits for im_work_en to go low.
  - ERR: entered from RUN when the watchdog reaches TIMEOUT_CYCLES-1 with no edge; om_timeout pulses once. Waits for im_work_en to go low.
- Watchdog:
  - Clears on every filtered edge and on entry to RUN.
  - Counts only in RUN and saturates.
- Simultaneous events:
  - im_work_en low takes priority over edge, done and timeout.
  - An edge in the same cycle the watchdog would expire clears the watchdog; no timeout occurs.
- om_busy = (state==ARM || state==RUN).

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding (IDLE, ARM, RUN, DONE, ERR).
  - Mode constants MODE0..MODE3 as {cpol,cpha}.
  - Default SYNC_STAGES and FILTER_LEN.
- One natural sub-module, spi_sync_filter: synchroniser, filter and registered rise/fall strobes. Parameters SYNC_STAGES and FILTER_LEN; ports clk, rst_n, din, level, rise, fall.

Test Plan:
- Mode 0, frame_bits=8, SCLK half-period 20 clk:
  - 8 sample_stb, each 6 clk after each rising pad edge.
  - 7 shift_stb; the 8th falling edge is suppressed in DONE.
  - frame_done 1 cycle after the 8th sample; bit_idx=8.
- Mode 3, frame_bits=16:
  - shift_stb on falling edges, sample_stb on rising edges.
  - 16 samples, then frame_done.
  - om_busy drops in DONE.
- Glitch filter: 2-clk high pulse on SCLK in RUN, mode 0 -> no strobe, bit_idx unchanged. A 3-clk pulse produces one sample_stb.
- Mode error: enable with im_cpol=1 while SCLK is held 0 -> mode_err=1 and the block stays in ARM. Raising SCLK clears mode_err after the filter latency, and RUN is entered.
- Timeout and abort:
  - Stall SCLK after 3 bits -> om_timeout pulses 1024 clk after the last edge; ERR holds.
  - Dropping im_work_en -> IDLE next cycle with bit_idx=0.
  - Mid-frame im_work_en drop at bit 5 -> IDLE, no frame_done.
- Boundaries:
  - frame_bits=0 -> frame ends after 32 samples.
  - rst_n low mid-frame -> all outputs 0 on the next clk edge.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave SCLK analyser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, SPI mode constants as {cpol,cpha} and the
// default synchroniser / glitch-filter depths.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILTER_LEN  = 3;

endpackage

// File: rtl/spi_sync_filter.sv
// SCLK synchroniser + glitch filter with registered rise/fall strobes.
// Latency: SYNC_STAGES + FILTER_LEN + 1 clk from first sampling edge to strobe.
// Backpressure: none; free-running, strobes are single-cycle and never held.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (all state loads 0)
//   din        : asynchronous SCLK from the pad
//   level      : filtered SCLK level
//   rise, fall : one-cycle strobes on a filtered level change
module spi_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILTER_LEN-1:0]  hist_q;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   all_hi, all_lo;

  assign all_hi = &hist_q;
  assign all_lo = ~|hist_q;

  // The level only moves once the whole history agrees on the new value,
  // so any run shorter than FILTER_LEN samples is swallowed.
  always_comb begin
    level_d = level_q;
    if (all_hi) begin
      level_d = 1'b1;
    end else if (all_lo) begin
      level_d = 1'b0;
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      hist_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q[0] <= sync_q[SYNC_STAGES-1];
      for (int i = 1; i < FILTER_LEN; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_sclk_edge_tracker.sv
// SPI slave SCLK analyser: filters SCLK, classifies edges per run-time mode, counts bits, watchdogs stalls.
// Latency: sample/shift strobes SYNC_STAGES+FILTER_LEN+1 clk after the pad edge; frame_done/timeout one clk later.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses to the shift register.
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   im_work_en     : frame enable, low aborts to IDLE
//   im_cpol/cpha   : SPI mode, latched when a frame is armed
//   im_frame_bits  : bits per frame, latched when armed (0 or >BIT_CNT_MAX means BIT_CNT_MAX)
//   im_sclk_wire   : raw asynchronous SCLK
//   om_sample_stb  : capture MOSI now
//   om_shift_stb   : drive next MISO bit now
//   om_bit_idx     : samples taken in this frame
//   om_frame_done  : pulse after the final sample
//   om_timeout     : pulse on watchdog expiry
//   om_mode_err    : SCLK not at the idle level while armed
//   om_busy        : high in ARM and RUN
module spi_sclk_edge_tracker
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int BIT_CNT_MAX    = 32,
  parameter int BIT_CNT_W      = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_W      = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 im_work_en,
  input  logic                 im_cpol,
  input  logic                 im_cpha,
  input  logic [BIT_CNT_W-1:0] im_frame_bits,
  input  logic                 im_sclk_wire,
  output logic                 om_sample_stb,
  output logic                 om_shift_stb,
  output logic [BIT_CNT_W-1:0] om_bit_idx,
  output logic                 om_frame_done,
  output logic                 om_timeout,
  output logic                 om_mode_err,
  output logic                 om_busy
);

  localparam logic [BIT_CNT_W-1:0] FLEN_MAX  = BIT_CNT_W'(BIT_CNT_MAX);
  localparam logic [BIT_CNT_W-1:0] IDX_ONE   = BIT_CNT_W'(1);
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WDOG_SAT  = '1;
  localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = TIMEOUT_W'(1);

  logic filt_level, filt_rise, filt_fall;

  spi_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (im_sclk_wire),
    .level (filt_level),
    .rise  (filt_rise),
    .fall  (filt_fall)
  );

  state_e               state_q, state_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [BIT_CNT_W-1:0] flen_q, flen_d;
  logic [BIT_CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;

  logic smp_edge, shf_edge, edge_any, in_run, last_smp;

  // Leading edge leaves the idle level, trailing edge returns to it; CPHA
  // picks which of the two captures MOSI.
  always_comb begin
    smp_edge = 1'b0;
    shf_edge = 1'b0;
    unique case ({cpol_q, cpha_q})
      MODE0: begin smp_edge = filt_rise; shf_edge = filt_fall; end
      MODE1: begin smp_edge = filt_fall; shf_edge = filt_rise; end
      MODE2: begin smp_edge = filt_fall; shf_edge = filt_rise; end
      MODE3: begin smp_edge = filt_rise; shf_edge = filt_fall; end
      default: begin smp_edge = 1'b0; shf_edge = 1'b0; end
    endcase
  end

  assign in_run        = (state_q == ST_RUN);
  assign edge_any      = filt_rise | filt_fall;
  assign om_sample_stb = in_run & smp_edge;
  assign om_shift_stb  = in_run & shf_edge;
  assign last_smp      = om_sample_stb && ((bit_idx_q + IDX_ONE) == flen_q);

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    flen_d    = flen_q;
    bit_idx_d = bit_idx_q;
    wdog_d    = wdog_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bit_idx_d = '0;
        wdog_d    = '0;
        if (im_work_en) begin
          state_d = ST_ARM;
          cpol_d  = im_cpol;
          cpha_d  = im_cpha;
          flen_d  = ((im_frame_bits == '0) || (im_frame_bits > FLEN_MAX)) ?
                    FLEN_MAX : im_frame_bits;
        end
      end
      ST_ARM: begin
        // Edges here are ignored; we only wait for SCLK to sit at idle.
        if (filt_level == cpol_q) begin
          state_d = ST_RUN;
          wdog_d  = '0;
        end
      end
      ST_RUN: begin
        if (om_sample_stb) begin
          bit_idx_d = bit_idx_q + IDX_ONE;
        end
        if (last_smp) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (edge_any) begin
          // An edge on the expiry cycle still rescues the frame.
          wdog_d = '0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d   = ST_ERR;
          timeout_d = 1'b1;
        end else if (wdog_q != WDOG_SAT) begin
          wdog_d = wdog_q + WDOG_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over every other event in the same cycle.
    if (!im_work_en) begin
      state_d   = ST_IDLE;
      bit_idx_d = '0;
      wdog_d    = '0;
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      flen_q    <= '0;
      bit_idx_q <= '0;
      wdog_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      flen_q    <= flen_d;
      bit_idx_q <= bit_idx_d;
      wdog_q    <= wdog_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign om_bit_idx    = bit_idx_q;
  assign om_frame_done = done_q;
  assign om_timeout    = timeout_q;
  assign om_mode_err   = (state_q == ST_ARM) && (filt_level != cpol_q);
  assign om_busy       = (state_q == ST_ARM) || (state_q == ST_RUN);

endmodule
